// File: rtl/ioctl_sdram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_sdram_loader_if
// Description : Bundle of the data_io ioctl download stream, the SDRAM slot
//               strobe and every loader result signal (SDRAM write port,
//               side port and status).
//               master modport : the side that drives ioctl_* and mem_sync
//                                and observes the loader results.
//               slave modport  : the loader itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ioctl_sdram_loader_if #(
    parameter int ADDR_W  = 25,
    parameter int SIDE_AW = 7
);
    // Download stream and memory slot strobe
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              mem_sync;

    // SDRAM CPU-port write request
    logic              loader_we;
    logic [ADDR_W-1:0] loader_addr;
    logic [7:0]        loader_data;

    // Side (bypass) port
    logic               side_we;
    logic [SIDE_AW-1:0] side_addr;
    logic [7:0]         side_data;

    // Status
    logic              busy;
    logic              overflow;
    logic [ADDR_W-1:0] byte_count;
    logic              done;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
        input  loader_we, loader_addr, loader_data,
        input  side_we, side_addr, side_data,
        input  busy, overflow, byte_count, done
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
        output loader_we, loader_addr, loader_data,
        output side_we, side_addr, side_data,
        output busy, overflow, byte_count, done
    );
endinterface
`default_nettype wire

// File: rtl/ioctl_sdram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_sdram_loader
// Description : Download-to-SDRAM bridge. Bytes from the data_io ioctl stream
//               are relocated by a per-index base address, buffered in a
//               small FIFO and issued at most one per mem_sync slot. One
//               configurable index is diverted to a side port instead.
// Ports       : clk_sys  - system clock
//               reset_n  - asynchronous active-low reset
//               bus      - ioctl_sdram_loader_if.slave:
//                          in : ioctl_download/index/wr/addr/dout, mem_sync
//                          out: loader_we/addr/data, side_we/addr/data,
//                               busy, overflow, byte_count, done
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_sdram_loader #(
    parameter int                            ADDR_W      = 25,
    parameter int                            FIFO_DEPTH  = 4,
    parameter int                            NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {25'h68000, 25'h80000},
    parameter logic [7:0]                    SIDE_INDEX  = 8'hFF,
    parameter int                            SIDE_AW     = 7
) (
    input  wire logic            clk_sys,
    input  wire logic            reset_n,
    ioctl_sdram_loader_if.slave  bus
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_ENTRY_W = ADDR_W + 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_dl_prev;
    logic [c_PTR_W:0]    r_wptr;
    logic [c_PTR_W:0]    r_rptr;
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];

    logic                r_loader_we;
    logic [ADDR_W-1:0]   r_loader_addr;
    logic [7:0]          r_loader_data;
    logic                r_side_we;
    logic [SIDE_AW-1:0]  r_side_addr;
    logic [7:0]          r_side_data;
    logic                r_overflow;
    logic [ADDR_W-1:0]   r_byte_count;

    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_reloc;
    logic                w_empty;
    logic                w_full;
    logic                w_wr_ok;
    logic                w_is_side;
    logic                w_accept;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_rise;
    logic                w_fall;

    // Indices at or beyond the last region all map onto the last region.
    always_comb begin
        w_base = REGION_BASE[(NUM_REGIONS-1)*ADDR_W +: ADDR_W];
        for (int i = 0; i < NUM_REGIONS - 1; i++) begin
            if (bus.ioctl_index == 8'(i)) begin
                w_base = REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Carry out of the top bit is intentionally discarded.
    assign w_reloc = w_base + bus.ioctl_addr;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                     (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);

    assign w_wr_ok   = bus.ioctl_wr && bus.ioctl_download;
    assign w_is_side = (bus.ioctl_index == SIDE_INDEX);
    assign w_accept  = w_wr_ok && !w_is_side && (r_state == ST_LOAD);
    assign w_pop     = bus.mem_sync && !w_empty;
    // A full FIFO still takes a byte if the head leaves in the same cycle.
    assign w_push    = w_accept && (!w_full || w_pop);
    assign w_drop    = w_accept && w_full && !w_pop;
    assign w_rise    = bus.ioctl_download && !r_dl_prev;
    assign w_fall    = !bus.ioctl_download && r_dl_prev;

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wptr[c_PTR_W-1:0]] <= {w_reloc, bus.ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_dl_prev     <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_loader_we   <= 1'b0;
            r_loader_addr <= '0;
            r_loader_data <= '0;
            r_side_we     <= 1'b0;
            r_side_addr   <= '0;
            r_side_data   <= '0;
            r_overflow    <= 1'b0;
            r_byte_count  <= '0;
        end else begin
            r_dl_prev <= bus.ioctl_download;

            if (w_push) begin
                r_wptr       <= r_wptr + (c_PTR_W+1)'(1);
                r_byte_count <= r_byte_count + ADDR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            // The write request only changes on slot boundaries so it stays
            // stable for the whole SDRAM slot.
            if (bus.mem_sync) begin
                if (!w_empty) begin
                    r_loader_we                    <= 1'b1;
                    {r_loader_addr, r_loader_data} <= r_mem[r_rptr[c_PTR_W-1:0]];
                    r_rptr                         <= r_rptr + (c_PTR_W+1)'(1);
                end else begin
                    r_loader_we <= 1'b0;
                end
            end

            r_side_we <= w_wr_ok && w_is_side;
            if (w_wr_ok && w_is_side) begin
                r_side_addr <= bus.ioctl_addr[SIDE_AW-1:0];
                r_side_data <= bus.ioctl_dout;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state      <= ST_LOAD;
                        r_overflow   <= 1'b0;
                        r_byte_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_fall) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Empty on a slot means the previous slot carried the
                    // final write and loader_we is now being dropped.
                    if (bus.mem_sync && w_empty) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.loader_we   = r_loader_we;
    assign bus.loader_addr = r_loader_addr;
    assign bus.loader_data = r_loader_data;
    assign bus.side_we     = r_side_we;
    assign bus.side_addr   = r_side_addr;
    assign bus.side_data   = r_side_data;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.overflow    = r_overflow;
    assign bus.byte_count  = r_byte_count;
    assign bus.done        = (r_state == ST_DONE);

endmodule
`default_nettype wire
